// File: rtl/miner_pkg.sv
// miner_pkg: shared widths, state encoding and result bundle
// for the nonce scheduler and its target comparator.
package miner_pkg;

    localparam int HDR_W   = 608;
    localparam int TGT_W   = 256;
    localparam int NONCE_W = 32;
    localparam int BLK_W   = 640;
    localparam int RES_W   = 288;
    localparam int RX_W    = HDR_W + TGT_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_COMPARE,
        S_REPORT
    } sched_state_t;

    typedef struct packed {
        logic [NONCE_W-1:0] nonce;
        logic [TGT_W-1:0]   digest;
    } miner_result_t;

endpackage

// File: rtl/target_cmp.sv
// target_cmp: unsigned 256-bit digest <= target check.
// Purely combinational; the scheduler samples it in COMPARE.
module target_cmp
    import miner_pkg::*;
(
    input  logic [TGT_W-1:0] digest_i,
    input  logic [TGT_W-1:0] target_i,
    output logic             hit_o
);

    // A digest at or below the target is a valid share.
    assign hit_o = (digest_i <= target_i);

endmodule

// File: rtl/nonce_scheduler.sv
// nonce_scheduler: steps nonces through an external hash core.
// Optional MINER_ABORT_EN: data_ready mid-unit restarts on new work.
module nonce_scheduler
    import miner_pkg::*;
#(
    parameter logic [NONCE_W-1:0] NONCE_INIT = 32'h0000_0000,
    parameter logic [NONCE_W-1:0] NONCE_STEP = 32'h0000_0001
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic [RX_W-1:0]  rx_data,
    input  logic             data_ready,
    output logic             hash_start,
    output logic [BLK_W-1:0] hash_block,
    input  logic             hash_done,
    input  logic [TGT_W-1:0] hash_digest,
    output logic [RES_W-1:0] tx_data,
    output logic             found,
    output logic             send_data,
    output logic             busy
);

    sched_state_t        state_q;
    logic [HDR_W-1:0]    hdr_q;
    logic [TGT_W-1:0]    tgt_q;
    logic [TGT_W-1:0]    dig_q;
    logic [NONCE_W-1:0]  nonce_q;
    miner_result_t       res_q;
    logic                found_q;
    logic                start_q;
    logic                send_q;
    logic                busy_q;

    logic                hit;
    logic [NONCE_W:0]    nonce_d;
    logic                last;
    logic                abort;
    logic                capture;
    logic                take_done;

    target_cmp u_cmp (
        .digest_i (dig_q),
        .target_i (tgt_q),
        .hit_o    (hit)
    );

    // Carry out of the 32-bit add marks the final nonce.
    assign nonce_d = {1'b0, nonce_q} + {1'b0, NONCE_STEP};
    assign last    = nonce_d[NONCE_W];

`ifdef MINER_ABORT_EN
    logic discard_q;

    assign abort = data_ready &&
                   (state_q == S_ISSUE ||
                    state_q == S_WAIT  ||
                    state_q == S_COMPARE);
    assign take_done = hash_done && !discard_q;

    // Drop the one result still in flight from an aborted unit.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            discard_q <= 1'b0;
        end else if (abort &&
                     (state_q == S_ISSUE ||
                      (state_q == S_WAIT && !take_done))) begin
            discard_q <= 1'b1;
        end else if (hash_done) begin
            discard_q <= 1'b0;
        end
    end
`else
    assign abort     = 1'b0;
    assign take_done = hash_done;
`endif

    assign capture = (data_ready && state_q == S_IDLE) || abort;

    // Work-unit sequencing with registered handshake outputs.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= S_IDLE;
            hdr_q   <= '0;
            tgt_q   <= '0;
            dig_q   <= '0;
            nonce_q <= '0;
            res_q   <= '0;
            found_q <= 1'b0;
            start_q <= 1'b0;
            send_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            start_q <= 1'b0;
            send_q  <= 1'b0;
            if (capture) begin
                hdr_q   <= rx_data[RX_W-1:TGT_W];
                tgt_q   <= rx_data[TGT_W-1:0];
                nonce_q <= NONCE_INIT;
                start_q <= 1'b1;
                busy_q  <= 1'b1;
                state_q <= S_ISSUE;
            end else begin
                unique case (state_q)
                    S_IDLE: begin
                        state_q <= S_IDLE;
                    end
                    S_ISSUE: begin
                        state_q <= S_WAIT;
                    end
                    S_WAIT: begin
                        if (take_done) begin
                            dig_q   <= hash_digest;
                            state_q <= S_COMPARE;
                        end
                    end
                    S_COMPARE: begin
                        if (hit || last) begin
                            res_q   <= '{nonce: nonce_q, digest: dig_q};
                            found_q <= hit;
                            send_q  <= 1'b1;
                            state_q <= S_REPORT;
                        end else begin
                            nonce_q <= nonce_d[NONCE_W-1:0];
                            start_q <= 1'b1;
                            state_q <= S_ISSUE;
                        end
                    end
                    S_REPORT: begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                    default: begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign hash_start = start_q;
    assign hash_block = {hdr_q, nonce_q};
    assign tx_data    = res_q;
    assign found      = found_q;
    assign send_data  = send_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_nonce_scheduler.sv
// tb_nonce_scheduler: random work units against a search model.
// Covers MINER_ABORT_EN when that macro is defined.
module tb_nonce_scheduler;

    localparam logic [31:0] I0 = 32'h0000_0000;
    localparam logic [31:0] I1 = 32'hFFFF_FFFE;
    localparam logic [255:0] TF = {4'hF, 252'b0};
    localparam logic [255:0] ALL1 = {256{1'b1}};

    logic         clk;
    logic         n_rst;
    logic [863:0] rx_data [2];
    logic         data_ready [2];
    logic         hash_start [2];
    logic [639:0] hash_block [2];
    logic         hash_done [2];
    logic [255:0] hash_digest [2];
    logic [287:0] tx_data [2];
    logic         found [2];
    logic         send_data [2];
    logic         busy [2];

    nonce_scheduler #(.NONCE_INIT(I0), .NONCE_STEP(32'h1)) dut0 (
        .clk(clk), .n_rst(n_rst),
        .rx_data(rx_data[0]), .data_ready(data_ready[0]),
        .hash_start(hash_start[0]), .hash_block(hash_block[0]),
        .hash_done(hash_done[0]), .hash_digest(hash_digest[0]),
        .tx_data(tx_data[0]), .found(found[0]),
        .send_data(send_data[0]), .busy(busy[0])
    );

    nonce_scheduler #(.NONCE_INIT(I1), .NONCE_STEP(32'h1)) dut1 (
        .clk(clk), .n_rst(n_rst),
        .rx_data(rx_data[1]), .data_ready(data_ready[1]),
        .hash_start(hash_start[1]), .hash_block(hash_block[1]),
        .hash_done(hash_done[1]), .hash_digest(hash_digest[1]),
        .tx_data(tx_data[1]), .found(found[1]),
        .send_data(send_data[1]), .busy(busy[1])
    );

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;

    logic [255:0] tgt [2];
    logic [255:0] hit_dig [2];
    logic [255:0] miss_dig [2];
    int           hit_idx [2];
    logic [31:0]  init [2];
    logic [31:0]  step [2];
    logic [607:0] exp_hdr [2];
    int           s_cyc [2];
    int           st_base [2];
    int           starts [2];
    int           sends [2];

    typedef struct {
        int          due;
        int          g;
        logic [31:0] n;
    } pend_t;
    pend_t pq[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag,
                         input logic [639:0] got,
                         input logic [639:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [255:0] dig_of(input int g,
                                            input logic [31:0] n);
        logic [31:0] idx;
        idx = (n - init[g]) / step[g];
        if (hit_idx[g] >= 0 && idx == 32'(hit_idx[g])) return hit_dig[g];
        return miss_dig[g];
    endfunction

    function automatic logic [255:0] rnd256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    function automatic logic [607:0] rnd_hdr();
        logic [607:0] r;
        for (int i = 0; i < 19; i++) r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    // Stub core: every start returns its digest 4 edges later.
    always @(posedge clk) begin
        hash_done[0] <= 1'b0;
        hash_done[1] <= 1'b0;
        while (pq.size() != 0 && pq[0].due == cyc) begin
            hash_done[pq[0].g]   <= 1'b1;
            hash_digest[pq[0].g] <= dig_of(pq[0].g, pq[0].n);
            void'(pq.pop_front());
        end
        for (int g = 0; g < 2; g++)
            if (hash_start[g])
                pq.push_back('{cyc + 4, g, hash_block[g][31:0]});
    end

    // Monitor: header and nonce sequence on every issued block.
    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (send_data[g]) sends[g]++;
            if (hash_start[g]) begin
                check("blk_hdr", 640'(hash_block[g][639:32]),
                      640'(exp_hdr[g]));
                check("blk_nonce", 640'(hash_block[g][31:0]),
                      640'(init[g] + step[g] * 32'(starts[g] - st_base[g])));
                if (starts[g] == st_base[g]) begin
                    check("first_lat", 640'(cyc - s_cyc[g]), 640'(1));
                    check("busy_up", 640'(busy[g]), 640'(1));
                end
                starts[g]++;
            end
        end
    end

    // Reference: first hit in nonce order, else the last nonce.
    task automatic model(input int g, output logic [31:0] en,
                         output logic [255:0] ed, output logic ef,
                         output int cnt);
        logic [63:0] n;
        n = {32'b0, init[g]};
        cnt = 0;
        en = '0;
        ed = '0;
        ef = 1'b0;
        for (int k = 0; k < 1000; k++) begin
            en = n[31:0];
            ed = dig_of(g, en);
            cnt++;
            if (ed <= tgt[g]) begin
                ef = 1'b1;
                return;
            end
            if (n + {32'b0, step[g]} > 64'hFFFF_FFFF) return;
            n = n + {32'b0, step[g]};
        end
    endtask

    task automatic setup(input int g, input logic [255:0] t,
                         input int hi, input logic [255:0] hd,
                         input logic [255:0] md);
        tgt[g] = t;
        hit_idx[g] = hi;
        hit_dig[g] = hd;
        miss_dig[g] = md;
    endtask

    task automatic launch(input int g, input logic [607:0] hdr);
        rx_data[g] = {hdr, tgt[g]};
        exp_hdr[g] = hdr;
        st_base[g] = starts[g];
        data_ready[g] = 1'b1;
        @(posedge clk);
        #1;
        data_ready[g] = 1'b0;
        s_cyc[g] = cyc - 1;
    endtask

    task automatic await_rep(input int g, input string tag);
        logic [31:0] en;
        logic [255:0] ed;
        logic ef;
        int cnt;
        bit seen;
        model(g, en, ed, ef, cnt);
        seen = 0;
        for (int k = 0; k < 3000 && !seen; k++) begin
            @(negedge clk);
            if (send_data[g]) seen = 1;
        end
        check({tag, "_seen"}, 640'(seen), 640'(1));
        if (seen) begin
            check({tag, "_lat"}, 640'(cyc - s_cyc[g]), 640'(7 * cnt + 1));
            check({tag, "_hashes"}, 640'(starts[g] - st_base[g]), 640'(cnt));
            check({tag, "_found"}, 640'(found[g]), 640'(ef));
            check({tag, "_tx"}, 640'(tx_data[g]), 640'({en, ed}));
            @(negedge clk);
            check({tag, "_pulse"}, 640'(send_data[g]), 640'(0));
            check({tag, "_idle"}, 640'(busy[g]), 640'(0));
        end
    endtask

    logic [607:0] h0;
    logic [607:0] h1;
    logic [255:0] t;
    logic [255:0] hd;
    logic [255:0] md;
    int n0;

    initial begin
        n_rst = 1'b0;
        for (int g = 0; g < 2; g++) begin
            data_ready[g] = 1'b0;
            rx_data[g] = '0;
            hit_idx[g] = -1;
            tgt[g] = '0;
            hit_dig[g] = '0;
            miss_dig[g] = ALL1;
            exp_hdr[g] = '0;
            s_cyc[g] = 0;
            st_base[g] = 0;
            starts[g] = 0;
            sends[g] = 0;
        end
        init[0] = I0;
        step[0] = 32'h1;
        init[1] = I1;
        step[1] = 32'h1;
        repeat (3) @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            check("rst_start", 640'(hash_start[g]), 640'(0));
            check("rst_send", 640'(send_data[g]), 640'(0));
            check("rst_busy", 640'(busy[g]), 640'(0));
            check("rst_found", 640'(found[g]), 640'(0));
            check("rst_tx", 640'(tx_data[g]), 640'(0));
            check("rst_blk", hash_block[g], 640'(0));
        end
        n_rst = 1'b1;
        @(negedge clk);

        h0 = rnd_hdr();
        h0[607:544] = 64'h0123_4567_89AB_CDEF;
        h1 = h0;
        h1[607:576] = 32'h0145_6789;

        setup(0, TF, 0, 256'd1, ALL1);
        launch(0, h0);
        await_rep(0, "hit0");

        setup(0, TF, 5, 256'd1, ALL1);
        launch(0, h0);
        await_rep(0, "hit5");

        setup(0, TF, 2, 256'd7, ALL1);
        launch(0, h1);
        await_rep(0, "chain");

        t = rnd256() >> 8;
        setup(0, t, 3, t, t + 256'd1);
        launch(0, rnd_hdr());
        await_rep(0, "exact");

        setup(1, TF, -1, 256'd0, ALL1);
        launch(1, rnd_hdr());
        await_rep(1, "exhaust");

        for (int r = 0; r < 6; r++) begin
            t = rnd256() >> $urandom_range(0, 40);
            t[255] = 1'b0;
            if ($urandom_range(0, 1) == 1) hd = t;
            else hd = t >> $urandom_range(1, 100);
            md = t + 256'd1 + 256'($urandom_range(0, 1000));
            setup(0, t, $urandom_range(0, 9), hd, md);
            launch(0, rnd_hdr());
            await_rep(0, "rand");
        end

        setup(0, TF, -1, 256'd0, ALL1);
        n0 = sends[0];
        launch(0, rnd_hdr());
        repeat (3) @(negedge clk);
        n_rst = 1'b0;
        #1;
        check("mid_start", 640'(hash_start[0]), 640'(0));
        check("mid_busy", 640'(busy[0]), 640'(0));
        check("mid_found", 640'(found[0]), 640'(0));
        check("mid_tx", 640'(tx_data[0]), 640'(0));
        check("mid_blk", hash_block[0], 640'(0));
        @(negedge clk);
        n_rst = 1'b1;
        repeat (12) @(negedge clk);
        check("late_send", 640'(sends[0] - n0), 640'(0));
        check("late_busy", 640'(busy[0]), 640'(0));
        check("late_starts", 640'(starts[0] - st_base[0]), 640'(1));

`ifdef MINER_ABORT_EN
        setup(0, TF, -1, 256'd0, ALL1);
        n0 = sends[0];
        launch(0, rnd_hdr());
        repeat (24) @(negedge clk);
        check("abort_pre", 640'(starts[0] - st_base[0]), 640'(4));
        setup(0, TF, 1, 256'd9, ALL1);
        launch(0, rnd_hdr());
        await_rep(0, "abort");
        check("abort_reports", 640'(sends[0] - n0), 640'(1));
`endif

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
